// File: rtl/osd_stm_pkg.sv
// Shared types and constants for the STM trace capture slice.
// Trace instructions are "addi x0, x0, imm" with a non-zero immediate.
package osd_stm_pkg;

  localparam logic [6:0] OP_IMM      = 7'h13;
  localparam logic [2:0] FUNCT3_ADDI = 3'h0;

  typedef struct packed {
    logic [15:0] id;
  } stm_tag_t;

  // True for "addi x0, x0, imm" with imm != 0; the all-zero immediate is the canonical NOP
  function automatic logic is_trace_insn(input logic [31:0] insn);
    return (insn[6:0] == OP_IMM) &&
           (insn[14:12] == FUNCT3_ADDI) &&
           (insn[11:7] == 5'd0) &&
           (insn[19:15] == 5'd0) &&
           (insn[31:20] != 12'd0);
  endfunction

endpackage

// File: rtl/osd_delay_line.sv
// Resettable shift register carrying a valid bit alongside a data word.
// Output appears DEPTH cycles after input; DEPTH must be at least 1.
module osd_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             delayed_valid,
  output logic [WIDTH-1:0] delayed_data
);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;

  // Shift valid/data one stage per cycle; reset flushes every stage so nothing in flight survives
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= valid;
      data_q[0]  <= data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign delayed_valid = valid_q[DEPTH-1];
  assign delayed_data  = data_q[DEPTH-1];

endmodule

// File: rtl/osd_stm_trace_capture.sv
// Watches the retire stream for trace instructions, reads the trace value
// register and emits one {id, value} event per trace instruction to the STM.
// Optional id range filter: define OSD_STM_CAPTURE_FILTER_EN.
// REG_LATENCY is expected to lie in 1..4.
module osd_stm_trace_capture
  import osd_stm_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int VALUE_REG      = 10,
  parameter int REG_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      retire_valid,
  input  logic [31:0]               retire_insn,
  output logic                      reg_read_enable,
  output logic [REG_ADDR_WIDTH-1:0] reg_read_addr,
  input  logic [XLEN-1:0]           reg_rdata,
  output logic                      trace_valid,
  output logic [15:0]               trace_id,
  output logic [XLEN-1:0]           trace_value,
  output logic [15:0]               trace_count
`ifdef OSD_STM_CAPTURE_FILTER_EN
  ,
  input  logic [15:0]               id_filter_lo,
  input  logic [15:0]               id_filter_hi
`endif
);

  stm_tag_t insn_tag;
  stm_tag_t delayed_tag;
  logic     filter_pass;
  logic     detect;
  logic     delayed_valid;

  assign insn_tag.id = {4'h0, retire_insn[31:20]};

`ifdef OSD_STM_CAPTURE_FILTER_EN
  assign filter_pass = (insn_tag.id >= id_filter_lo) && (insn_tag.id <= id_filter_hi);
`else
  assign filter_pass = 1'b1;
`endif

  assign detect = !rst && retire_valid && enable && is_trace_insn(retire_insn) && filter_pass;

  // Issue the value-register read in the same cycle the trace instruction retires
  always_comb begin
    reg_read_enable = 1'b0;
    reg_read_addr   = '0;
    if (detect) begin
      reg_read_enable = 1'b1;
      reg_read_addr   = REG_ADDR_WIDTH'(VALUE_REG);
    end
  end

  osd_delay_line #(
    .WIDTH($bits(stm_tag_t)),
    .DEPTH(REG_LATENCY)
  ) u_delay (
    .clk           (clk),
    .rst           (rst),
    .valid         (detect),
    .data          (insn_tag),
    .delayed_valid (delayed_valid),
    .delayed_data  (delayed_tag)
  );

  // Pair the emerging id with the read data and register the event; id/value hold between events
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_valid <= 1'b0;
      trace_id    <= '0;
      trace_value <= '0;
      trace_count <= '0;
    end else begin
      trace_valid <= delayed_valid;
      if (delayed_valid) begin
        trace_id    <= delayed_tag.id;
        trace_value <= reg_rdata;
        trace_count <= trace_count + 16'd1;
      end
    end
  end

endmodule
